// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with device ACK check
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_WAIT_DEV,
    ST_SEND,
    ST_ACK,
    ST_FINISH,
    ST_ABORT
  } state_t;

  localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] START_LAST   = 20'(START_TIMEOUT - 1);
  localparam logic [19:0] XFER_LAST    = 20'(XFER_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  data;
  logic        parity;
  logic [3:0]  bit_cnt;
  logic [19:0] timer;

  logic clk_s1, clk_s2, clk_prev;
  logic dat_s1, dat_s2;
  logic fall;

  // Synchronisers reset to the idle-high line level so release never looks like an edge.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat_in;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      data       <= 8'd0;
      parity     <= 1'b0;
      bit_cnt    <= 4'd0;
      timer      <= 20'd0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_code   <= 2'd0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            data       <= cmd_data;
            parity     <= ~^cmd_data;
            bit_cnt    <= 4'd0;
            timer      <= 20'd0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b0;
            state      <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (timer == INHIBIT_LAST) begin
            timer      <= 20'd0;
            ps2_dat_oe <= 1'b1;
            state      <= ST_REQ;
          end else begin
            timer <= timer + 20'd1;
          end
        end

        // Start bit is already on DAT when the clock is let go.
        ST_REQ: begin
          ps2_clk_oe <= 1'b0;
          timer      <= 20'd0;
          state      <= ST_WAIT_DEV;
        end

        ST_WAIT_DEV: begin
          if (fall) begin
            ps2_dat_oe <= ~data[0];
            timer      <= 20'd0;
            bit_cnt    <= 4'd1;
            state      <= ST_SEND;
          end else if (timer == START_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            done       <= 1'b1;
            err_code   <= 2'd1;
            state      <= ST_ABORT;
          end else begin
            timer <= timer + 20'd1;
          end
        end

        ST_SEND: begin
          if (timer == XFER_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            done       <= 1'b1;
            err_code   <= 2'd2;
            state      <= ST_ABORT;
          end else begin
            timer <= timer + 20'd1;
            if (fall) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt <= 4'd7) begin
                ps2_dat_oe <= ~data[bit_cnt[2:0]];
              end else if (bit_cnt == 4'd8) begin
                ps2_dat_oe <= ~parity;
              end else begin
                ps2_dat_oe <= 1'b0;
                state      <= ST_ACK;
              end
            end
          end
        end

        ST_ACK: begin
          if (timer == XFER_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            done       <= 1'b1;
            err_code   <= 2'd2;
            state      <= ST_ABORT;
          end else begin
            timer <= timer + 20'd1;
            if (fall) begin
              if (!dat_s2) begin
                state <= ST_FINISH;
              end else begin
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                done       <= 1'b1;
                err_code   <= 2'd3;
                state      <= ST_ABORT;
              end
            end
          end
        end

        // Hold off until the device has let both lines float back up.
        ST_FINISH: begin
          if (clk_s2 && dat_s2) begin
            done      <= 1'b1;
            err_code  <= 2'd0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        ST_ABORT: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          busy       <= 1'b0;
          cmd_ready  <= 1'b1;
          state      <= ST_IDLE;
        end

        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          busy       <= 1'b0;
          cmd_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized bench for ps2_host_tx with a bit-level device model
module tb_ps2_host_tx;

  localparam int INH   = 200;
  localparam int START = 600;
  localparam int XFER  = 900;

  logic       CLOCK_50;
  logic       resetn;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       busy, done;
  logic [1:0] err_code;
  logic       dev_clk_low, dev_dat_low;
  logic       clk_line, dat_line;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int ff_cyc   = 0;
  logic [10:0] dev_rx;

  assign clk_line = ~ps2_clk_oe & ~dev_clk_low;
  assign dat_line = ~ps2_dat_oe & ~dev_dat_low;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (START),
    .XFER_TIMEOUT  (XFER)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .ps2_clk_in(clk_line),
    .ps2_dat_in(dat_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .done      (done),
    .err_code  (err_code)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  always @(posedge CLOCK_50) cyc <= cyc + 1;
  always @(negedge CLOCK_50) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line sequence: start, D0..D7, odd parity, stop (index 0 = start).
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic dev_clock(input logic [7:0] b, input int n, input bit ack, input int h);
    dev_rx = '0;
    if (n > 0) begin
      repeat ($urandom_range(40, 5)) @(negedge CLOCK_50);
      dev_rx[0] = dat_line;
      for (int k = 1; k <= n; k++) begin
        if (k == 11) begin
          dev_dat_low = ack;
          repeat (2) @(negedge CLOCK_50);
        end
        dev_clk_low = 1'b1;
        if (k == 1) begin
          ff_cyc = cyc;
          repeat (2) @(negedge CLOCK_50);
          check("d0_not_yet", {31'b0, ps2_dat_oe}, 32'd1);
          @(negedge CLOCK_50);
          check("d0_at_3", {31'b0, ps2_dat_oe}, {31'b0, !b[0]});
          repeat (h - 3) @(negedge CLOCK_50);
        end else begin
          repeat (h) @(negedge CLOCK_50);
        end
        dev_clk_low = 1'b0;
        if (k <= 10) dev_rx[k] = dat_line;
        repeat (h) @(negedge CLOCK_50);
      end
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic accept(input logic [7:0] b);
    int n;
    n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
    end
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
    check("acc_clk_oe", {31'b0, ps2_clk_oe}, 32'd1);
    check("acc_busy", {31'b0, busy}, 32'd1);
    check("acc_ready", {31'b0, cmd_ready}, 32'd0);
  endtask

  task automatic run_txn(input logic [7:0] b, input int n, input bit ack, input int exp_code,
                         input bit measure, input bit queue_next, input logic [7:0] next_b);
    int hold, t_wait, h, nd, d_cyc;
    h = $urandom_range(16, 8);
    hold = 1;
    while (hold < 2000) begin
      @(negedge CLOCK_50);
      if (!ps2_clk_oe) break;
      hold++;
    end
    t_wait = cyc;
    if (measure) check("inhibit_len", hold, INH + 1);
    check("start_bit", {31'b0, dat_line}, 32'd0);
    if (queue_next) begin
      cmd_data  = next_b;
      cmd_valid = 1'b1;
    end
    fork
      dev_clock(b, n, ack, h);
      begin
        nd = 0;
        while (!done && nd < 3000) begin
          @(negedge CLOCK_50);
          nd++;
        end
        d_cyc = cyc;
        check("done_seen", {31'b0, done}, 32'd1);
        check("err_code", {30'b0, err_code}, exp_code);
        check("end_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
        check("end_dat_oe", {31'b0, ps2_dat_oe}, 32'd0);
        if (exp_code == 1) check("start_timeout", d_cyc - t_wait, START);
        if (exp_code == 2) check("xfer_timeout", d_cyc - ff_cyc, XFER + 3);
        @(negedge CLOCK_50);
        check("done_width", {31'b0, done}, 32'd0);
        if (queue_next) begin
          check("q_idle_busy", {31'b0, busy}, 32'd0);
          check("q_idle_ready", {31'b0, cmd_ready}, 32'd1);
          @(negedge CLOCK_50);
          check("q_accept_clk", {31'b0, ps2_clk_oe}, 32'd1);
          check("q_accept_busy", {31'b0, busy}, 32'd1);
          cmd_valid = 1'b0;
        end
      end
    join
    if (exp_code == 0) check("frame", {21'b0, dev_rx}, {21'b0, frame_of(b)});
  endtask

  initial begin
    int n, snap;
    logic [7:0] rb;
    resetn      = 1'b0;
    cmd_valid   = 1'b0;
    cmd_data    = 8'd0;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    check("rst_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {30'b0, err_code}, 32'd0);
    check("rst_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
    check("rst_dat_oe", {31'b0, ps2_dat_oe}, 32'd0);

    accept(8'hF4); run_txn(8'hF4, 11, 1'b1, 0, 1'b1, 1'b0, 8'h00);
    accept(8'h00); run_txn(8'h00, 11, 1'b1, 0, 1'b1, 1'b0, 8'h00);
    accept(8'hFF); run_txn(8'hFF, 11, 1'b1, 0, 1'b1, 1'b0, 8'h00);
    accept(8'h3C); run_txn(8'h3C, 0, 1'b0, 1, 1'b1, 1'b0, 8'h00);
    accept(8'h5A); run_txn(8'h5A, 5, 1'b0, 2, 1'b1, 1'b0, 8'h00);
    accept(8'h81); run_txn(8'h81, 11, 1'b0, 3, 1'b1, 1'b1, 8'hFF);
    run_txn(8'hFF, 11, 1'b1, 0, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      accept(rb);
      run_txn(rb, 11, 1'b1, 0, 1'b1, 1'b0, 8'h00);
    end

    // Reset while the host is driving D4 (0 in 0xA5, so DAT is being pulled low).
    accept(8'hA5);
    n = 0;
    while (ps2_clk_oe && n < 2000) begin
      @(negedge CLOCK_50);
      n++;
    end
    dev_clock(8'hA5, 5, 1'b0, 10);
    check("pre_rst_dat_oe", {31'b0, ps2_dat_oe}, 32'd1);
    snap = done_cnt;
    resetn = 1'b0;
    #1;
    check("mid_rst_dat_oe", {31'b0, ps2_dat_oe}, 32'd0);
    check("mid_rst_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    check("post_rst_no_done", done_cnt, snap);

    rb = 8'($urandom);
    accept(rb);
    run_txn(rb, 11, 1'b1, 0, 1'b1, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
